// File: rtl/inv_key_schedule_128.sv
// AES-128 decryption key schedule: emits round keys 10 down to 0 over a valid/ready handshake.
// Accepts either the cipher key (runs the forward schedule first) or the round-10 key.
module inv_key_schedule_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_is_last,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         done
);

  localparam int unsigned KeyW  = 128;
  localparam int unsigned WordW = 32;
  localparam int unsigned RndW  = 4;
  localparam logic [RndW-1:0] LastRnd = RndW'(10);

  typedef enum logic [1:0] {IDLE, PRECOMP, EMIT} state_e;

  state_e            state_q;
  logic [KeyW-1:0]   key_q, key_d;
  logic [RndW-1:0]   rnd_q, rnd_d;
  logic              busy_q, valid_q, done_q;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box: inverse as x^254 (0 maps to 0), then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, inv;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [RndW-1:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [WordW-1:0] w0, w1, w2, w3;
  logic [WordW-1:0] inv_w1, inv_w2, inv_w3, inv_w0;
  logic [WordW-1:0] fwd_w0, fwd_w1, fwd_w2, fwd_w3;
  logic [WordW-1:0] sub_src, rot, sub_out, t_word;
  logic [RndW-1:0]  rc_idx;
  logic             hs;

  assign {w0, w1, w2, w3} = key_q;
  assign hs = valid_q & key_ready;

  assign inv_w3 = w3 ^ w2;
  assign inv_w2 = w2 ^ w1;
  assign inv_w1 = w1 ^ w0;

  // One SubWord shared by both directions; only the source word differs
  assign sub_src = (state_q == PRECOMP) ? w3 : inv_w3;
  assign rot     = {sub_src[23:0], sub_src[31:24]};
  assign rc_idx  = (state_q == PRECOMP) ? rnd_q + RndW'(1) : rnd_q;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_out[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign t_word = sub_out ^ {rcon(rc_idx), 24'h000000};

  assign fwd_w0 = w0 ^ t_word;
  assign fwd_w1 = w1 ^ fwd_w0;
  assign fwd_w2 = w2 ^ fwd_w1;
  assign fwd_w3 = w3 ^ fwd_w2;
  assign inv_w0 = w0 ^ t_word;

  // Datapath next-state
  always_comb begin
    key_d = key_q;
    rnd_d = rnd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d = key_in;
          rnd_d = key_is_last ? LastRnd : '0;
        end
      end
      PRECOMP: begin
        key_d = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
        rnd_d = rnd_q + RndW'(1);
      end
      EMIT: begin
        if (hs && (rnd_q != '0)) begin
          key_d = {inv_w0, inv_w1, inv_w2, inv_w3};
          rnd_d = rnd_q - RndW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      key_q  <= key_d;
      rnd_q  <= rnd_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (key_is_last) begin
              valid_q <= 1'b1;
              state_q <= EMIT;
            end else begin
              state_q <= PRECOMP;
            end
          end
        end
        PRECOMP: begin
          if (rnd_q == LastRnd - RndW'(1)) begin
            valid_q <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (hs && (rnd_q == '0)) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign key_valid = valid_q;
  assign key_out   = key_q;
  assign round_out = rnd_q;
  assign done      = done_q;

endmodule

// File: doc/inv_key_schedule_128.md
# inv_key_schedule_128

Decryption-side AES-128 key schedule. The block produces round keys in reverse order (10 down to 0), one per accepted handshake, so the inverse cipher can consume them on the fly without storing all 1408 bits of expanded key. It accepts either the cipher key or the round-10 key. When given the cipher key, it first runs the forward schedule internally for 10 cycles. It sits between the key-load logic and the inverse-round datapath, alongside the forward key expansion.

## Interface
- No parameters. Key size is fixed at 128 bits and Nr is fixed at 10.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request a new schedule. Sampled only while busy=0.
- key_in  in  128  key word order {w0,w1,w2,w3}, w0 = key_in[127:96]; byte 0 of each word is its MSB.
- key_is_last  in  1  sampled with start. 1 = key_in is the round-10 key; 0 = key_in is the cipher key.
- busy  out  1  high from the cycle after start is accepted until the final handshake.
- key_valid  out  1  key_out and round_out are valid.
- key_ready  in  1  consumer accepts key_out this cycle when key_valid=1.
- key_out  out  128  current round key, same word and byte order as key_in.
- round_out  out  4  round index of key_out, counting 10 down to 0.
- done  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- States:
  - IDLE: waits for start.
  - PRECOMP: runs the forward schedule.
  - EMIT: presents round keys to the consumer.
- Registers: key_reg[127:0] and rnd[3:0]. key_out = key_reg. round_out = rnd.
- IDLE, start=1, key_is_last=1: key_reg←key_in, rnd←10, go to EMIT.
- IDLE, start=1, key_is_last=0: key_reg←key_in, rnd←0, go to PRECOMP.
- PRECOMP, each cycle, forward step with rc=Rcon(rnd+1):
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
  - rnd←rnd+1; go to EMIT when the new rnd is 10.
- EMIT, handshake (key_valid & key_ready) with rnd>0, inverse step with rc=Rcon(rnd):
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
  - w0'=w0^SubWord(RotWord(w3'))^{rc,24'h0}
  - rnd←rnd−1
- EMIT, handshake with rnd=0: go to IDLE, pulse done.
- EMIT without handshake: key_reg and rnd hold.
- RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36.
- SubWord is four instances of the existing sboxModule. They are shared between PRECOMP and EMIT through a mux on the SubWord input.
- start while busy=1 is ignored; no queuing. start in the same cycle as the final handshake is also ignored.
- key_in and key_is_last are don't-care except in the start cycle.
- rnd never leaves 0..10. No wrap-around.

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, key_reg=0, rnd=0. All outputs 0: busy, key_valid, done, key_out, round_out.
- Reset asserted mid-PRECOMP or mid-EMIT aborts immediately. After release the block is in IDLE and done is not pulsed.
- Outputs are registered only: key_out, round_out, key_valid, busy, done. No combinational path from key_ready to any output.
- key_is_last=1: key_valid rises the cycle after the start edge (latency 1), with round_out=10.
- key_is_last=0: key_valid rises 10 cycles after the start edge, with round_out=10. During PRECOMP, key_valid=0 and busy=1.
- With key_ready held at 1, rounds 10..0 are emitted on 11 consecutive cycles.
- done is high for exactly one cycle, the cycle after the round-0 handshake. key_valid and busy fall in that same cycle.
- The next start is accepted in that done cycle at the earliest.
- Minimum full schedule is 12 cycles from start to done (key_is_last=1) or 21 cycles (key_is_last=0).

## Test plan
- FIPS-197 A.1, key_is_last=0, key_in=2b7e151628aed2a6abf7158809cf4f3c, key_ready=1:
  - key_valid is first seen 10 cycles after start, with round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e1516….
  - done pulses one cycle after round 0.
- key_is_last=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6:
  - Same 11 keys as above, first one 1 cycle after start.
- Back-pressure: key_ready toggles randomly (including 0 for 5 consecutive cycles at round 5):
  - key_out and round_out are stable while unaccepted.
  - No round is skipped or repeated.
  - Sequence is identical to the first test.
- start pulsed during PRECOMP and during EMIT with a different key_in:
  - Ignored; output sequence unchanged.
  - A new start in the done cycle begins a fresh schedule.
- rst_n asserted at round 6 in EMIT:
  - All outputs go to 0 immediately; no done pulse.
  - A subsequent start yields the correct full sequence.
- All-zero and all-ones cipher keys:
  - Inverse outputs match a software forward-expansion model in reverse for all 11 rounds.
